dram_arbiter: RTL
=================

Name: dram_arbiter

Overview:
- Shares the single DRAM port between the layer engines: conv, pool and fc, plus the parameter loader.
- Performs round-robin arbitration with bounded bursts, so no engine can starve another.
- Muxes each engine's address, write data and enables onto the DRAM.
- Routes read-data valid strobes back to the engine that issued each read.
- Sits between the layer engines and the DRAM model/controller.

Parameters:
- DATA_WIDTH, 32, DRAM word width.
- ADDR_WIDTH, 18, DRAM word address width.
- NUM_REQ, 4, number of requesters (index 0 has highest initial priority).
- MAX_BURST, 25, maximum consecutive beats per grant when others wait (one kernel channel).
- RD_LAT, 1, DRAM read latency in cycles (1..4).

Ports:
- clk  input  1  clock.
- srstn  input  1  reset.
- req  input  NUM_REQ  per-requester access request, held high while accesses remain.
- req_wr  input  NUM_REQ  1 = write beat, 0 = read beat; sampled with req.
- req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  input  NUM_REQ*DATA_WIDTH  packed write data, same packing.
- gnt  output  NUM_REQ  one-hot grant; a beat occurs each cycle gnt[i] & req[i].
- rd_valid  output  NUM_REQ  one-hot; rd_data is valid for requester i.
- rd_data  output  DATA_WIDTH  read data, broadcast to all requesters.
- dram_rdata  input  DATA_WIDTH  DRAM read data.
- dram_addr  output  ADDR_WIDTH  DRAM address.
- dram_wdata  output  DATA_WIDTH  DRAM write data.
- dram_en_rd  output  1  DRAM read enable.
- dram_en_wr  output  1  DRAM write enable.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Clock port is clk; reset port is srstn.

Reset values:
- state=ST_IDLE, owner=0, rr_ptr=0, beat_cnt=0, response pipeline cleared.
- gnt=0, rd_valid=0, dram_en_rd=0, dram_en_wr=0, dram_addr=0, dram_wdata=0.
- Reset asserted mid-burst or with reads in flight: everything is cleared immediately and the in-flight responses are dropped (no rd_valid).

FSM states: ST_IDLE, ST_BUSY.

ST_IDLE:
- If any req is high, owner <= the first requesting index at or after rr_ptr, searching cyclically.
- beat_cnt <= 0; go to ST_BUSY.
- gnt is 0 in ST_IDLE.

ST_BUSY:
- gnt = onehot(owner), registered state.
- DRAM outputs are combinational muxes of owner's fields, gated by req[owner]:
  - dram_en_rd = req[owner] & ~req_wr[owner]
  - dram_en_wr = req[owner] & req_wr[owner]
- When no beat occurs, dram_addr and dram_wdata are 0.
- Beat: beat_cnt increments, wrapping to 0 after MAX_BURST-1.

Release from ST_BUSY:
- Release when req[owner]==0, or when beat_cnt==MAX_BURST-1 with a beat and any other req high.
- On release: state <= ST_IDLE and rr_ptr <= owner+1 mod NUM_REQ.
- This gives a one-cycle turnaround bubble with gnt=0.
- If beat_cnt hits MAX_BURST-1 and no other requester is waiting, ownership continues and beat_cnt wraps to 0.

Request timing:
- Requester drops req in the cycle after its last beat.
- A beat is counted in the cycle req falls only if req is high in that cycle.

Read response:
- RD_LAT-deep shift register of {valid, owner id}.
- rd_valid[id] is asserted exactly RD_LAT cycles after the read beat; rd_data = dram_rdata.
- Responses complete even after the owner changes.

Ordering:
- Writes need no response.
- Read-after-write to the same address by the same requester returns the new data (DRAM ordering is preserved).

Optional Feature:
- Macro: DRAM_ARB_PERF_EN.
- Defined:
  - Adds a per-requester 32-bit beat counter, saturating at 0xFFFFFFFF and cleared by reset.
  - Adds a per-requester 16-bit maximum wait-cycle register, measured from req rising to first grant.
  - Adds output perf_beats (NUM_REQ*32) and output perf_maxwait (NUM_REQ*16).
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
1. Single requester 1 reads 25 addresses 0x0100..0x0118 -> gnt[1] from cycle 2; dram_addr tracks the addresses; rd_valid[1] one cycle after each beat; no other rd_valid.
2. Requesters 0 and 2 request simultaneously from reset, each with 30 reads -> 0 granted first; after 25 beats, 1 bubble cycle, then 2 gets 25 beats; bubble; 0 gets its remaining 5; bubble; 2 gets its remaining 5.
3. Requester 3 writes 0xDEADBEEF to 0x00040 then reads 0x00040 -> dram_en_wr then dram_en_rd; rd_data = 0xDEADBEEF with rd_valid[3].
4. Requester 0 alone issues 60 continuous reads -> no bubble at beats 25 and 50; gnt[0] stays high for 60 cycles.
5. Requester 1 read at RD_LAT=3 as its last beat, then requester 2 is granted -> rd_valid[1] arrives 3 cycles after the beat, during 2's grant.
6. srstn pulsed low mid-burst with 1 read in flight -> all outputs 0 asynchronously, no rd_valid afterwards; arbitration restarts from requester 0.

Source files
------------

// File: rtl/dram_arbiter_if.sv
// ---------------------------------------------------------------------------
// dram_arbiter_if
// Requester-side bus of the DRAM arbiter. Every layer engine and the
// parameter loader sits on one slot of the packed vectors.
//   req       : per-requester access request (held while beats remain)
//   req_wr    : 1 = write beat, 0 = read beat
//   req_addr  : packed word addresses, slot i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata : packed write data, same packing
//   gnt       : one-hot grant; a beat happens every cycle gnt[i] & req[i]
//   rd_valid  : one-hot, rd_data belongs to requester i this cycle
//   rd_data   : read data, broadcast to all requesters
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface dram_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            req_wr;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            rd_valid;
    logic [DATA_WIDTH-1:0]         rd_data;

    modport master (
        output req, req_wr, req_addr, req_wdata,
        input  gnt, rd_valid, rd_data
    );

    modport slave (
        input  req, req_wr, req_addr, req_wdata,
        output gnt, rd_valid, rd_data
    );
endinterface

// File: rtl/dram_arbiter.sv
// ---------------------------------------------------------------------------
// dram_arbiter
// Shares one DRAM port between the conv / pool / fc engines and the
// parameter loader. Round-robin arbitration with bounded bursts: an owner
// keeps the port for at most MAX_BURST beats while someone else waits,
// then a one-cycle gnt=0 turnaround hands it to the next requester.
// Read responses are tagged with the issuing requester and come back as
// rd_valid[id] exactly RD_LAT cycles after the read beat, even if the
// owner has changed meanwhile.
//
// Ports:
//   clk, srstn      clock, asynchronous active-low reset
//   bus (slave)     requester bus, see dram_arbiter_if
//   dram_rdata      DRAM read data (RD_LAT cycles after dram_en_rd)
//   dram_addr       DRAM word address (0 when no beat)
//   dram_wdata      DRAM write data   (0 when no beat)
//   dram_en_rd/wr   DRAM read / write enables
//
// Optional feature, macro DRAM_ARB_PERF_EN:
//   perf_beats   NUM_REQ x 32-bit saturating beat counters
//   perf_maxwait NUM_REQ x 16-bit max wait from req rise to first grant
// ---------------------------------------------------------------------------
module dram_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 25,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  srstn,
    dram_arbiter_if.slave         bus,
    input  logic [DATA_WIDTH-1:0] dram_rdata,
    output logic [ADDR_WIDTH-1:0] dram_addr,
    output logic [DATA_WIDTH-1:0] dram_wdata,
    output logic                  dram_en_rd,
    output logic                  dram_en_wr
`ifdef DRAM_ARB_PERF_EN
    ,
    output logic [NUM_REQ*32-1:0] perf_beats,
    output logic [NUM_REQ*16-1:0] perf_maxwait
`endif
);

    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [OW-1:0] LAST_REQ  = OW'(NUM_REQ - 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t          state_reg;
    logic [OW-1:0]   owner_reg;
    logic [OW-1:0]   rr_ptr_reg;
    logic [BW-1:0]   beat_cnt_reg;

    // Unpacked views of the packed requester fields
    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];
    logic [NUM_REQ-1:0]    owner_oh;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi] = bus.req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign owner_oh[gi]  = (owner_reg == OW'(gi));
        end
    endgenerate

    logic busy;
    logic owner_req;
    logic owner_wr;
    logic beat;
    logic burst_end;
    logic others_req;
    logic release_now;
    logic [OW-1:0] next_ptr;

    assign busy        = (state_reg == ST_BUSY);
    assign owner_req   = bus.req[owner_reg];
    assign owner_wr    = bus.req_wr[owner_reg];
    assign beat        = busy & owner_req;
    assign burst_end   = beat & (beat_cnt_reg == LAST_BEAT);
    assign others_req  = |(bus.req & ~owner_oh);
    // Give up the port when the owner is done, or when its burst budget is
    // spent and somebody else is waiting. A lone owner just keeps going.
    assign release_now = busy & (~owner_req | (burst_end & others_req));
    assign next_ptr    = (owner_reg == LAST_REQ) ? '0 : owner_reg + OW'(1);

    // First requester at or after rr_ptr, searching cyclically
    logic          pick_found;
    logic [OW-1:0] pick_idx;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int c;
            c = int'(rr_ptr_reg) + k;
            if (c >= NUM_REQ) begin
                c = c - NUM_REQ;
            end
            if (!pick_found && bus.req[c]) begin
                pick_found = 1'b1;
                pick_idx   = OW'(c);
            end
        end
    end

    // Arbitration FSM
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            state_reg    <= ST_IDLE;
            owner_reg    <= '0;
            rr_ptr_reg   <= '0;
            beat_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pick_found) begin
                        owner_reg    <= pick_idx;
                        beat_cnt_reg <= '0;
                        state_reg    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (beat) begin
                        beat_cnt_reg <= burst_end ? '0 : beat_cnt_reg + BW'(1);
                    end
                    if (release_now) begin
                        state_reg  <= ST_IDLE;
                        rr_ptr_reg <= next_ptr;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Grant is a pure decode of registered state
    assign bus.gnt = busy ? owner_oh : '0;

    // DRAM side: owner's fields, only while a beat actually happens
    assign dram_en_rd = beat & ~owner_wr;
    assign dram_en_wr = beat & owner_wr;
    assign dram_addr  = beat ? addr_arr[owner_reg]  : '0;
    assign dram_wdata = beat ? wdata_arr[owner_reg] : '0;

    // Read response pipeline: {valid, id} follows the DRAM latency so the
    // data lands at the requester that issued the read.
    logic          rd_vld_reg [RD_LAT];
    logic [OW-1:0] rd_id_reg  [RD_LAT];

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            rd_vld_reg[0] <= 1'b0;
            rd_id_reg[0]  <= '0;
        end else begin
            rd_vld_reg[0] <= dram_en_rd;
            rd_id_reg[0]  <= owner_reg;
        end
    end

    generate
        for (gi = 1; gi < RD_LAT; gi++) begin : g_rd_pipe
            always_ff @(posedge clk or negedge srstn) begin
                if (!srstn) begin
                    rd_vld_reg[gi] <= 1'b0;
                    rd_id_reg[gi]  <= '0;
                end else begin
                    rd_vld_reg[gi] <= rd_vld_reg[gi-1];
                    rd_id_reg[gi]  <= rd_id_reg[gi-1];
                end
            end
        end

        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rd_valid
            assign bus.rd_valid[gi] = rd_vld_reg[RD_LAT-1] &&
                                      (rd_id_reg[RD_LAT-1] == OW'(gi));
        end
    endgenerate

    assign bus.rd_data = dram_rdata;

`ifdef DRAM_ARB_PERF_EN
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_perf
            logic [31:0] beats_reg;
            logic [15:0] wait_reg;
            logic [15:0] max_reg;
            logic        served_reg;
            logic        granted;

            assign granted = beat && owner_oh[gi];

            always_ff @(posedge clk or negedge srstn) begin
                if (!srstn) begin
                    beats_reg  <= '0;
                    wait_reg   <= '0;
                    max_reg    <= '0;
                    served_reg <= 1'b0;
                end else begin
                    if (granted && (beats_reg != '1)) begin
                        beats_reg <= beats_reg + 32'd1;
                    end
                    // Wait window opens when req rises and closes at the
                    // first granted beat; dropping req re-arms it.
                    if (!bus.req[gi]) begin
                        served_reg <= 1'b0;
                        wait_reg   <= '0;
                    end else if (!served_reg) begin
                        if (granted) begin
                            served_reg <= 1'b1;
                            if (wait_reg > max_reg) begin
                                max_reg <= wait_reg;
                            end
                        end else if (wait_reg != '1) begin
                            wait_reg <= wait_reg + 16'd1;
                        end
                    end
                end
            end

            assign perf_beats[gi*32 +: 32]   = beats_reg;
            assign perf_maxwait[gi*16 +: 16] = max_reg;
        end
    endgenerate
`endif

endmodule
